// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage.
// Holds the fetch FSM encoding and datapath widths.
package fetch_unit_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_HOLD  = 2'd2,
    FS_HALT  = 2'd3
  } fs_t;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads imem over req/ack,
// and hands instr/pc to decode over valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int                CNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc_current,
  input  logic               instr_ready,
  input  logic [ADDR_W-1:0]  pc_next,
  input  logic               halt,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count
);

  fs_t               state;
  logic [ADDR_W-1:0] pc;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  assign imem_addr  = pc;
  assign pc_current = pc;

  // Fetch FSM with all handshake outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FS_FETCH;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      unique case (state)
        FS_FETCH: begin
          if (halt) begin
            halted <= 1'b1;
            state  <= FS_HALT;
          end else begin
            imem_req <= 1'b1;
            state    <= FS_WAIT;
          end
        end
        FS_WAIT: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= FS_HOLD;
          end
        end
        FS_HOLD: begin
          if (instr_ready) begin
            pc          <= pc_next;
            instr_valid <= 1'b0;
            if (!(&fetch_count))
              fetch_count <= fetch_count + CNT_ONE;
            state       <= FS_FETCH;
          end
        end
        FS_HALT: begin
          if (!halt) begin
            halted <= 1'b0;
            state  <= FS_FETCH;
          end
        end
        default: state <= FS_FETCH;
      endcase
    end
  end

endmodule
